forward_hazard_unit: RTL

- Control-side counterpart of the execute stage's forwarding datapath.
- Tracks destination-register state for the EX, MEM and WB pipeline slots.
- Generates the per-cycle select codes consumed by the execute stage's sr1/sr2/pc/dest forwarding muxes.
- Detects load-use hazards and drives the stall/bubble controls that the pipeline registers obey.

---
 rtl/forward_hazard_unit_if.sv | 53 +++++
 rtl/forward_hazard_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// FWD_HAZARD_STATS_EN adds the stall/forward statistics counters.
interface forward_hazard_unit_if #(
    parameter int REGW = 3
);
    logic [REGW-1:0] id_sr1;
    logic [REGW-1:0] id_sr2;
    logic [REGW-1:0] id_src;
    logic            id_sr1_used;
    logic            id_sr2_used;
    logic            id_src_used;
    logic [REGW-1:0] id_dest;
    logic            id_regwrite;
    logic            id_is_load;
    logic            id_dest_is_pc;
    logic            id_link;
    logic            id_valid;
    logic            mem_stall;
    logic            br_flush;

    logic [1:0]      sr1_forward_sel;
    logic [1:0]      sr2_forward_sel;
    logic            pc_forward_sel;
    logic            dest_forward_sel;
    logic            stall_id;
    logic            bubble_ex;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0]     stall_count;
    logic [15:0]     fwd_count;
`endif

    modport master (
        output id_sr1, id_sr2, id_src, id_sr1_used, id_sr2_used, id_src_used,
               id_dest, id_regwrite, id_is_load, id_dest_is_pc, id_link, id_valid,
               mem_stall, br_flush,
        input  sr1_forward_sel, sr2_forward_sel, pc_forward_sel, dest_forward_sel,
               stall_id, bubble_ex
`ifdef FWD_HAZARD_STATS_EN
        , input stall_count, fwd_count
`endif
    );

    modport slave (
        input  id_sr1, id_sr2, id_src, id_sr1_used, id_sr2_used, id_src_used,
               id_dest, id_regwrite, id_is_load, id_dest_is_pc, id_link, id_valid,
               mem_stall, br_flush,
        output sr1_forward_sel, sr2_forward_sel, pc_forward_sel, dest_forward_sel,
               stall_id, bubble_ex
`ifdef FWD_HAZARD_STATS_EN
        , output stall_count, fwd_count
`endif
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use hazard control for the EX/MEM/WB slots.
// Define FWD_HAZARD_STATS_EN to add saturating stall/forward counters.
module forward_hazard_unit #(
    parameter int REGW = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    forward_hazard_unit_if.slave   hz_if
);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] dest;
        logic            regwrite;
        logic            is_load;
        logic            dest_is_pc;
        logic            link;
    } slot_t;

    typedef struct packed {
        slot_t           slot;
        logic [REGW-1:0] sr1;
        logic [REGW-1:0] sr2;
        logic [REGW-1:0] src;
        logic            sr1_used;
        logic            sr2_used;
        logic            src_used;
    } ex_slot_t;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] dest;
        logic            regwrite;
    } wb_slot_t;

    ex_slot_t exSlot_q, exSlot_d;
    slot_t    memSlot_q, memSlot_d;
    wb_slot_t wbSlot_q, wbSlot_d;

    logic [1:0] sr1Sel;
    logic [1:0] sr2Sel;
    logic       pcSel;
    logic       destSel;
    logic       loadUse;
    logic       storeHaz;
    logic       hazard;
    logic       stallId;
    logic       bubbleEx;

    // MEM never forwards a load: its data is not back from memory yet.
    function automatic logic memHit(input slot_t s, input logic [REGW-1:0] r);
        return s.valid && s.regwrite && !s.is_load && (s.dest == r);
    endfunction

    function automatic logic wbHit(input wb_slot_t s, input logic [REGW-1:0] r);
        return s.valid && s.regwrite && (s.dest == r);
    endfunction

    function automatic logic [1:0] srSelect(input logic used, input logic [REGW-1:0] r,
                                            input slot_t m, input wb_slot_t w);
        if (!used)
            return 2'b00;
        if (memHit(m, r))
            return m.dest_is_pc ? 2'b11 : 2'b10;
        if (wbHit(w, r))
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exDestHit(input ex_slot_t e, input logic used,
                                       input logic [REGW-1:0] r);
        return e.slot.valid && e.slot.regwrite && used && (e.slot.dest == r);
    endfunction

    always_comb begin
        sr1Sel  = srSelect(exSlot_q.slot.valid && exSlot_q.sr1_used, exSlot_q.sr1,
                           memSlot_q, wbSlot_q);
        sr2Sel  = srSelect(exSlot_q.slot.valid && exSlot_q.sr2_used, exSlot_q.sr2,
                           memSlot_q, wbSlot_q);
        pcSel   = memSlot_q.valid && memSlot_q.dest_is_pc && memSlot_q.link;
        destSel = exSlot_q.slot.valid && exSlot_q.src_used
                  && wbHit(wbSlot_q, exSlot_q.src) && !memHit(memSlot_q, exSlot_q.src);

        // A store source written by the EX instruction would only be reachable
        // from MEM next cycle, which the dest mux cannot select, so stall once.
        loadUse  = exSlot_q.slot.is_load
                   && (exDestHit(exSlot_q, hz_if.id_sr1_used, hz_if.id_sr1)
                    || exDestHit(exSlot_q, hz_if.id_sr2_used, hz_if.id_sr2)
                    || exDestHit(exSlot_q, hz_if.id_src_used, hz_if.id_src));
        storeHaz = exDestHit(exSlot_q, hz_if.id_src_used, hz_if.id_src);
        hazard   = !reset && hz_if.id_valid && (loadUse || storeHaz)
                   && !hz_if.mem_stall && !hz_if.br_flush;
        stallId  = !reset && (hz_if.mem_stall || hazard);
        bubbleEx = !reset && !hz_if.mem_stall && (hazard || hz_if.br_flush);
    end

    assign hz_if.sr1_forward_sel  = reset ? 2'b00 : sr1Sel;
    assign hz_if.sr2_forward_sel  = reset ? 2'b00 : sr2Sel;
    assign hz_if.pc_forward_sel   = !reset && pcSel;
    assign hz_if.dest_forward_sel = !reset && destSel;
    assign hz_if.stall_id         = stallId;
    assign hz_if.bubble_ex        = bubbleEx;

    always_comb begin
        exSlot_d  = exSlot_q;
        memSlot_d = memSlot_q;
        wbSlot_d  = wbSlot_q;
        if (!hz_if.mem_stall) begin
            wbSlot_d.valid    = memSlot_q.valid;
            wbSlot_d.dest     = memSlot_q.dest;
            wbSlot_d.regwrite = memSlot_q.regwrite;
            memSlot_d         = exSlot_q.slot;
            if (bubbleEx) begin
                exSlot_d = '0;
            end else begin
                exSlot_d.slot.valid      = hz_if.id_valid;
                exSlot_d.slot.dest       = hz_if.id_dest;
                exSlot_d.slot.regwrite   = hz_if.id_regwrite;
                exSlot_d.slot.is_load    = hz_if.id_is_load;
                exSlot_d.slot.dest_is_pc = hz_if.id_dest_is_pc;
                exSlot_d.slot.link       = hz_if.id_link;
                exSlot_d.sr1             = hz_if.id_sr1;
                exSlot_d.sr2             = hz_if.id_sr2;
                exSlot_d.src             = hz_if.id_src;
                exSlot_d.sr1_used        = hz_if.id_sr1_used;
                exSlot_d.sr2_used        = hz_if.id_sr2_used;
                exSlot_d.src_used        = hz_if.id_src_used;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exSlot_q  <= '0;
            memSlot_q <= '0;
            wbSlot_q  <= '0;
        end else begin
            exSlot_q  <= exSlot_d;
            memSlot_q <= memSlot_d;
            wbSlot_q  <= wbSlot_d;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stallCount_q, stallCount_d;
    logic [15:0] fwdCount_q, fwdCount_d;

    // Only hazard stalls are counted; memory-wait cycles are excluded.
    always_comb begin
        stallCount_d = stallCount_q;
        fwdCount_d   = fwdCount_q;
        if (hazard && (stallCount_q != 16'hFFFF))
            stallCount_d = stallCount_q + 16'd1;
        if (((sr1Sel != 2'b00) || (sr2Sel != 2'b00)) && !hz_if.mem_stall
            && (fwdCount_q != 16'hFFFF))
            fwdCount_d = fwdCount_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount_q <= 16'd0;
            fwdCount_q   <= 16'd0;
        end else begin
            stallCount_q <= stallCount_d;
            fwdCount_q   <= fwdCount_d;
        end
    end

    assign hz_if.stall_count = stallCount_q;
    assign hz_if.fwd_count   = fwdCount_q;
`endif

endmodule
